// File: rtl/fp_share_pkg.sv
// fp_share_pkg: shared types and sizing helpers for the FP share server.
package fp_share_pkg;
    localparam int unsigned DBL_W = 64;

    typedef struct packed {
        logic [DBL_W-1:0] a;
        logic [DBL_W-1:0] b;
    } fp_req_t;

    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fp_share_server_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at a registered pointer that moves
// past the winner only when the grant is actually taken.
module rr_arbiter
    import fp_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_any
);
    logic [IW-1:0] ptr_q, ptr_d, idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt_any     = 1'b1;
                gnt_id      = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
        ptr_d = !accept ? ptr_q : (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/fp_share_server.sv
// fp_share_server: time-shares one valid/ready/finish FP core among several
// client ports; results return to the issuer in issue order via a tag FIFO.
module fp_share_server
    import fp_share_pkg::*;
#(
    parameter int DBL_WIDTH    = 64,
    parameter int N_CLIENTS    = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CLIENTS-1:0]           cli_valid,
    input  logic [N_CLIENTS*DBL_WIDTH-1:0] cli_a,
    input  logic [N_CLIENTS*DBL_WIDTH-1:0] cli_b,
    output logic [N_CLIENTS-1:0]           cli_ready,
    output logic [N_CLIENTS-1:0]           cli_finish,
    output logic [N_CLIENTS*DBL_WIDTH-1:0] cli_result,
    output logic                           core_valid,
    output logic [DBL_WIDTH-1:0]           core_a,
    output logic [DBL_WIDTH-1:0]           core_b,
    input  logic                           core_ready,
    input  logic                           core_finish,
    input  logic [DBL_WIDTH-1:0]           core_result,
    output logic                           protocol_err
);
    localparam int IW = id_w(N_CLIENTS);
    localparam int AW = $clog2(MAX_INFLIGHT);

    logic [N_CLIENTS-1:0] pend_vld_q, pend_vld_d, busy_q, busy_d, cli_finish_q, cli_finish_d;
    logic [DBL_WIDTH-1:0] pend_a_q [N_CLIENTS];
    logic [DBL_WIDTH-1:0] pend_a_d [N_CLIENTS];
    logic [DBL_WIDTH-1:0] pend_b_q [N_CLIENTS];
    logic [DBL_WIDTH-1:0] pend_b_d [N_CLIENTS];
    logic [DBL_WIDTH-1:0] res_q    [N_CLIENTS];
    logic [DBL_WIDTH-1:0] res_d    [N_CLIENTS];
    logic [IW-1:0]        fifo_q   [MAX_INFLIGHT];
    logic [IW-1:0]        fifo_d   [MAX_INFLIGHT];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic                 core_valid_q, core_valid_d, err_q, err_d;
    logic [DBL_WIDTH-1:0] core_a_q, core_a_d, core_b_q, core_b_d;
    logic [N_CLIENTS-1:0] gnt_oh, cap;
    logic [IW-1:0]        gnt_id, head;
    logic                 gnt_any, issue, pop, empty, full;

    assign cli_ready    = ~(pend_vld_q | busy_q);
    assign cap          = cli_valid & cli_ready;
    assign empty        = (wr_q == rd_q);
    assign full         = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head         = fifo_q[rd_q[AW-1:0]];
    // core_valid_q blocks back-to-back issue so every core_valid is a single-cycle pulse
    assign issue        = gnt_any && core_ready && !full && !core_valid_q;
    assign pop          = core_finish && !empty;
    assign cli_finish   = cli_finish_q;
    assign core_valid   = core_valid_q;
    assign core_a       = core_a_q;
    assign core_b       = core_b_q;
    assign protocol_err = err_q;

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_res
        assign cli_result[i*DBL_WIDTH +: DBL_WIDTH] = res_q[i];
    end

    rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (pend_vld_q),
        .accept (issue),
        .gnt_oh (gnt_oh),
        .gnt_id (gnt_id),
        .gnt_any(gnt_any)
    );

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cli_finish_d[i] = pop && (head == IW'(i));
            pend_a_d[i]     = cap[i] ? cli_a[i*DBL_WIDTH +: DBL_WIDTH] : pend_a_q[i];
            pend_b_d[i]     = cap[i] ? cli_b[i*DBL_WIDTH +: DBL_WIDTH] : pend_b_q[i];
            res_d[i]        = cli_finish_d[i] ? core_result : res_q[i];
        end
        pend_vld_d   = (pend_vld_q & ~(issue ? gnt_oh : '0)) | cap;
        busy_d       = (busy_q | (issue ? gnt_oh : '0)) & ~cli_finish_d;
        core_valid_d = issue;
        core_a_d     = issue ? pend_a_q[gnt_id] : core_a_q;
        core_b_d     = issue ? pend_b_q[gnt_id] : core_b_q;
        fifo_d       = fifo_q;
        fifo_d[wr_q[AW-1:0]] = issue ? gnt_id : fifo_q[wr_q[AW-1:0]];
        wr_d         = wr_q + (AW+1)'(issue);
        rd_d         = rd_q + (AW+1)'(pop);
        err_d        = err_q | (|(cli_valid & ~cli_ready)) | (core_finish && empty);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend_vld_q   <= '0;
            busy_q       <= '0;
            cli_finish_q <= '0;
            pend_a_q     <= '{default: '0};
            pend_b_q     <= '{default: '0};
            res_q        <= '{default: '0};
            fifo_q       <= '{default: '0};
            wr_q         <= '0;
            rd_q         <= '0;
            core_valid_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            pend_vld_q   <= pend_vld_d;
            busy_q       <= busy_d;
            cli_finish_q <= cli_finish_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            res_q        <= res_d;
            fifo_q       <= fifo_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            core_valid_q <= core_valid_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            err_q        <= err_d;
        end
endmodule

// File: tb/tb_fp_share_server.sv
// tb_fp_share_server: random and directed traffic against a transaction-level
// model (per-client outstanding ops, issue-order list, behavioural FP core).
module tb_fp_share_server;
    import fp_share_pkg::*;
    localparam int N = 4, W = 64, MAXI = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]   cli_valid = '0;
    logic [N*W-1:0] cli_a = '0, cli_b = '0;
    logic [N-1:0]   cli_ready, cli_finish;
    logic [N*W-1:0] cli_result;
    logic           core_valid, core_ready = 1'b1, core_finish = 1'b0, protocol_err;
    logic [W-1:0]   core_a, core_b, core_result = '0;

    fp_share_server #(.DBL_WIDTH(W), .N_CLIENTS(N), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .cli_valid(cli_valid), .cli_a(cli_a), .cli_b(cli_b),
        .cli_ready(cli_ready), .cli_finish(cli_finish), .cli_result(cli_result),
        .core_valid(core_valid), .core_a(core_a), .core_b(core_b), .core_ready(core_ready),
        .core_finish(core_finish), .core_result(core_result), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mulb(input logic [W-1:0] a, input logic [W-1:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    typedef struct { int due; logic [W-1:0] r; } sch_t;
    sch_t         sched[$];
    fp_req_t      unis[N][$];
    logic [W-1:0] prod[N][$];
    logic [W-1:0] exp_res[N];
    int           outst[N];
    int           iss_q[$], grants[$];
    int           last_due = 0, lat = 3, inflight = 0, max_infl = 0;
    int           acc_cnt = 0, fin_seen = 0, sent = 0, seq = 1;
    logic [N-1:0] exp_fin = '0, m_rdy, m_nf;
    bit           err_exp = 0, prev_cv = 0, rdy_rand = 0, inj = 0, m_err;
    int           m_c;

    // Transaction-level model: a client is ready iff it has no accepted, unfinished op.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rdy", 64'(cli_ready), 64'(4'hf));
            chk("rst_fin", 64'(cli_finish), 0);
            chk("rst_cv", 64'(core_valid), 0);
            chk("rst_err", 64'(protocol_err), 0);
            chk("rst_res", 64'(|cli_result), 0);
            for (int i = 0; i < N; i++) begin
                outst[i] = 0;
                unis[i].delete();
                prod[i].delete();
            end
            iss_q.delete();
            inflight = 0;
            exp_fin  = '0;
            err_exp  = 0;
            prev_cv  = 0;
        end else begin
            m_err = 0;
            chk("fin", 64'(cli_finish), 64'(exp_fin));
            if (|cli_finish) fin_seen++;
            for (int i = 0; i < N; i++)
                if (exp_fin[i]) begin
                    chk($sformatf("res%0d", i), cli_result[i*W +: W], exp_res[i]);
                    outst[i]--;
                end
            for (int i = 0; i < N; i++) m_rdy[i] = (outst[i] == 0);
            chk("rdy", 64'(cli_ready), 64'(m_rdy));
            chk("err", 64'(protocol_err), 64'(err_exp));
            if (core_valid) begin
                chk("cv_gap", 64'(prev_cv), 0);
                m_c = -1;
                for (int i = 0; i < N; i++)
                    if (m_c < 0 && unis[i].size() > 0 && unis[i][0].a == core_a && unis[i][0].b == core_b)
                        m_c = i;
                chk("iss_match", 64'(m_c >= 0), 1);
                if (m_c >= 0) begin
                    void'(unis[m_c].pop_front());
                    iss_q.push_back(m_c);
                    grants.push_back(m_c);
                end
                inflight++;
                max_infl = (inflight > max_infl) ? inflight : max_infl;
                chk("infl", 64'(inflight <= MAXI), 1);
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                sched.push_back('{due: last_due, r: mulb(core_a, core_b)});
            end
            prev_cv = core_valid;
            m_nf = '0;
            if (core_finish) begin
                if (inflight == 0) m_err = 1;
                else begin
                    inflight--;
                    if (iss_q.size() > 0) begin
                        m_c = iss_q.pop_front();
                        m_nf[m_c] = 1'b1;
                        exp_res[m_c] = prod[m_c].pop_front();
                    end
                end
            end
            for (int i = 0; i < N; i++)
                if (cli_valid[i]) begin
                    if (outst[i] == 0) begin
                        outst[i] = 1;
                        unis[i].push_back(fp_req_t'({cli_a[i*W +: W], cli_b[i*W +: W]}));
                        prod[i].push_back(mulb(cli_a[i*W +: W], cli_b[i*W +: W]));
                        acc_cnt++;
                    end else m_err = 1;
                end
            if (m_err) err_exp = 1;
            exp_fin = m_nf;
        end
    end

    // One cycle; operands are scrambled whenever valid is not being driven.
    task automatic step();
        @(posedge clk);
        #1;
        cli_valid = '0;
        for (int k = 0; k < N*W/32; k++) begin
            cli_a[k*32 +: 32] = $urandom;
            cli_b[k*32 +: 32] = $urandom;
        end
        core_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sched.size() > 0 && sched[0].due <= cyc) begin
            core_finish = 1'b1;
            core_result = sched[0].r;
            void'(sched.pop_front());
        end else begin
            core_finish = inj;
            core_result = {$urandom, $urandom};
        end
    endtask

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        cli_valid[i]     = 1'b1;
        cli_a[i*W +: W]  = a;
        cli_b[i*W +: W]  = b;
        sent++;
    endtask

    task automatic rsend(input int i);
        seq++;
        send(i, $realtobits(real'(seq*8 + i)), $realtobits(real'($urandom_range(1, 50))));
    endtask

    function automatic bit any_out();
        for (int i = 0; i < N; i++) if (outst[i] != 0) return 1;
        return 0;
    endfunction

    task automatic drain(input string tag);
        int k = 0;
        while (k < 600 && (sched.size() > 0 || inflight > 0 || any_out())) begin
            step();
            k++;
        end
        chk(tag, 64'(k < 600), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired @cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, k, f0, s0, g0, n;
        do_reset();

        c0 = cyc;
        send(2, 64'h4008000000000000, 64'h4000000000000000);
        step();
        chk("t1_rdy_low", 64'(cli_ready[2]), 0);
        chk("t1_cv_c1", 64'(core_valid), 0);
        step();
        chk("t1_cv_c2", 64'(core_valid), 1);
        chk("t1_core_a", core_a, 64'h4008000000000000);
        chk("t1_core_b", core_b, 64'h4000000000000000);
        k = 0;
        while (!cli_finish[2] && k < 20) begin step(); k++; end
        chk("t1_fin_cyc", 64'(cyc - c0), 6);
        chk("t1_result", cli_result[2*W +: W], 64'h4018000000000000);
        drain("t1_drain");

        do_reset();
        g0 = grants.size();
        for (int i = 0; i < N; i++) rsend(i);
        step();
        drain("t2_drain");
        chk("t2_ngrants", 64'(grants.size() - g0), 4);
        for (int i = 0; i < N; i++) chk($sformatf("t2_order%0d", i), 64'(grants[g0 + i]), 64'(i));

        lat = 20;
        max_infl = 0;
        s0 = sent;
        f0 = fin_seen;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) if (outst[i] == 0) rsend(i);
            step();
        end
        drain("t3_drain");
        chk("t3_ops", 64'(fin_seen - f0), 64'(sent - s0));
        chk("t3_maxinfl", 64'(max_infl), 64'(MAXI));
        lat = 3;

        f0 = acc_cnt;
        n = 1;
        rsend(0);
        for (int t = 0; t < 500 && n < 10; t++) begin
            step();
            if (cli_finish[0]) begin rsend(0); n++; end
        end
        step();
        drain("t4_drain");
        chk("t4_accepted", 64'(acc_cnt - f0), 10);
        chk("t4_no_err", 64'(protocol_err), 0);

        rdy_rand = 1;
        for (int t = 0; t < 400; t++) begin
            lat = $urandom_range(1, 6);
            for (int i = 0; i < N; i++)
                if (outst[i] == 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0)) rsend(i);
            step();
        end
        rdy_rand = 0;
        lat = 3;
        drain("rand_drain");

        do_reset();
        rsend(1);
        step();
        step();
        rsend(1);
        step();
        chk("t5_err_drop", 64'(protocol_err), 1);
        drain("t5_drain");
        f0 = fin_seen;
        inj = 1;
        step();
        inj = 0;
        step();
        step();
        chk("t5_spur_fin", 64'(fin_seen - f0), 0);
        chk("t5_err_held", 64'(protocol_err), 1);

        do_reset();
        lat = 10;
        for (int i = 0; i < 3; i++) rsend(i);
        for (int t = 0; t < 7; t++) step();
        chk("t6_inflight", 64'(inflight), 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rdy", 64'(cli_ready), 64'(4'hf));
        chk("t6_rst_cv", 64'(core_valid), 0);
        chk("t6_rst_fin", 64'(cli_finish), 0);
        chk("t6_rst_err", 64'(protocol_err), 0);
        step();
        step();
        rst_n = 1'b1;
        f0 = fin_seen;
        for (int t = 0; t < 15; t++) step();
        chk("t6_late_fin", 64'(fin_seen - f0), 0);
        chk("t6_late_err", 64'(protocol_err), 1);
        chk("t6_sched_empty", 64'(sched.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
